// File: rtl/macc_engine.sv
// Square matrix multiply-accumulate engine: C = A * B over N x N signed matrices.
// A and B are loaded serially through din, C is read back serially through dout.
module macc_engine #(
  parameter  int DW = 16,
  parameter  int N  = 4,
  localparam int CW = 2*DW + $clog2(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [1:0]    wen,
  input  logic [DW-1:0] din,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          ren,
  output logic [CW-1:0] dout,
  output logic          dout_valid,
  output logic          a_full,
  output logic          b_full,
  output logic [1:0]    state_dbg
);
  localparam int NN = N*N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(NN);

  typedef enum logic [1:0] {IDLE = 2'd0, COMP = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nx;

  logic [IW-1:0]        i, j, k;
  logic [AW-1:0]        a_ptr, b_ptr, c_ptr;
  logic [AW-1:0]        a_addr, b_addr, c_addr;
  logic signed [CW-1:0] acc, acc_nx;
  logic signed [2*DW-1:0] prod;
  logic                 k_last, j_last, i_last, last_mac;
  logic                 a_we, b_we, c_we, rd_en;

  logic signed [DW-1:0] a_mem [NN];
  logic signed [DW-1:0] b_mem [NN];
  logic [CW-1:0]        c_mem [NN];

  // Handshake: wen/start/ren are single-cycle requests sampled on the rising
  // edge and only honoured while busy is low; dout_valid marks the cycle after
  // an accepted ren.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  assign a_we  = wen[1] && !busy;
  assign b_we  = wen[0] && !busy;
  assign rd_en = ren && !busy;

  assign k_last   = (k == IW'(N-1));
  assign j_last   = (j == IW'(N-1));
  assign i_last   = (i == IW'(N-1));
  assign last_mac = (state == COMP) && i_last && j_last && k_last;
  assign c_we     = (state == COMP) && k_last;

  assign a_addr = AW'(int'(i) * N + int'(k));
  assign b_addr = AW'(int'(k) * N + int'(j));
  assign c_addr = AW'(int'(i) * N + int'(j));

  always_comb begin
    prod   = a_mem[a_addr] * b_mem[b_addr];
    acc_nx = ((k == '0) ? CW'(0) : acc) + CW'(prod);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = COMP;
      COMP:    if (last_mac) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      acc        <= '0;
      a_ptr      <= '0;
      b_ptr      <= '0;
      c_ptr      <= '0;
      a_full     <= 1'b0;
      b_full     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state <= state_nx;

      if (a_we) begin
        a_ptr <= (a_ptr == AW'(NN-1)) ? '0 : a_ptr + 1'b1;
        if (a_ptr == AW'(NN-1)) a_full <= 1'b1;
      end
      if (b_we) begin
        b_ptr <= (b_ptr == AW'(NN-1)) ? '0 : b_ptr + 1'b1;
        if (b_ptr == AW'(NN-1)) b_full <= 1'b1;
      end

      dout_valid <= rd_en;
      if (rd_en) begin
        dout  <= c_mem[c_ptr];
        c_ptr <= (c_ptr == AW'(NN-1)) ? '0 : c_ptr + 1'b1;
      end

      if (state == IDLE && start) begin
        i <= '0;
        j <= '0;
        k <= '0;
      end

      // k is innermost, then j (column), then i (row).
      if (state == COMP) begin
        acc <= acc_nx;
        if (k_last) begin
          k <= '0;
          if (j_last) begin
            j <= '0;
            i <= i_last ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end else begin
          k <= k + 1'b1;
        end
      end

      // Entering DONE rearms loading and rewinds readback for the new result.
      if (last_mac) begin
        a_ptr  <= '0;
        b_ptr  <= '0;
        c_ptr  <= '0;
        a_full <= 1'b0;
        b_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (a_we) a_mem[a_ptr] <= din;
    if (b_we) b_mem[b_ptr] <= din;
    if (c_we) c_mem[c_addr] <= acc_nx;
  end

endmodule

// File: tb/tb_macc_engine.sv
// Directed bench for macc_engine (N=4, DW=16) with a reference matrix model
// and an expected-value queue for C readback.
module tb_macc_engine;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int NN = N*N;
  localparam int CW = 2*DW + $clog2(N);

  logic          CLK;
  logic          RST;
  logic [1:0]    wen;
  logic [DW-1:0] din;
  logic          start;
  logic          busy;
  logic          done;
  logic          ren;
  logic [CW-1:0] dout;
  logic          dout_valid;
  logic          a_full;
  logic          b_full;
  logic [1:0]    state_dbg;

  macc_engine #(.DW(DW), .N(N)) dut (
    .CLK(CLK), .RST(RST), .wen(wen), .din(din), .start(start),
    .busy(busy), .done(done), .ren(ren), .dout(dout),
    .dout_valid(dout_valid), .a_full(a_full), .b_full(b_full),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference model state
  int            ma [NN];
  int            mb [NN];
  logic [CW-1:0] mc [NN];
  int            m_aptr = 0, m_bptr = 0, m_cptr = 0;
  logic          m_afull = 1'b0, m_bfull = 1'b0;
  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] last_exp = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // scoreboard: every dout_valid pops one expected C element
  always @(negedge CLK) begin
    if (!RST && dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dout_valid", 64'(dout), 64'hDEAD);
      end else begin
        last_exp = exp_q.pop_front();
        chk("dout", 64'(dout), 64'(last_exp));
      end
    end
  end

  task automatic model_compute();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        longint s;
        s = 0;
        for (int kk = 0; kk < N; kk++)
          s += longint'(ma[r*N+kk]) * longint'(mb[kk*N+c]);
        mc[r*N+c] = s[CW-1:0];
      end
  endtask

  task automatic model_reset();
    m_aptr = 0; m_bptr = 0; m_cptr = 0;
    m_afull = 1'b0; m_bfull = 1'b0;
  endtask

  // driver: one write cycle, model updated alongside
  task automatic write_ab(input logic [1:0] w, input logic [DW-1:0] d);
    wen = w; din = d;
    step();
    wen = 2'b00;
    if (w[1]) begin
      ma[m_aptr] = int'($signed(d));
      if (m_aptr == NN-1) m_afull = 1'b1;
      m_aptr = (m_aptr + 1) % NN;
    end
    if (w[0]) begin
      mb[m_bptr] = int'($signed(d));
      if (m_bptr == NN-1) m_bfull = 1'b1;
      m_bptr = (m_bptr + 1) % NN;
    end
    chk("a_full", 64'(a_full), 64'(m_afull));
    chk("b_full", 64'(b_full), 64'(m_bfull));
  endtask

  task automatic load_random();
    for (int n = 0; n < NN; n++) write_ab(2'b10, 16'($urandom_range(0, 65535)));
    for (int n = 0; n < NN; n++) write_ab(2'b01, 16'($urandom_range(0, 65535)));
  endtask

  task automatic read_c(input int count);
    for (int n = 0; n < count; n++) begin
      exp_q.push_back(mc[m_cptr]);
      m_cptr = (m_cptr + 1) % NN;
      ren = 1'b1;
      step();
    end
    ren = 1'b0;
    step();
    chk("dout_valid_idle", 64'(dout_valid), 64'd0);
    chk("dout_hold", 64'(dout), 64'(last_exp));
  endtask

  // start a compute; optionally read in the start cycle and/or poke wen/start while busy
  task automatic run_compute(input bit rd_same, input bit junk);
    int cnt;
    if (rd_same) begin
      exp_q.push_back(mc[m_cptr]);
      m_cptr = (m_cptr + 1) % NN;
      ren = 1'b1;
    end
    model_compute();
    start = 1'b1;
    step();
    start = 1'b0;
    ren = 1'b0;
    cnt = 1;
    chk("busy_in_comp", 64'(busy), 64'd1);
    while (done !== 1'b1 && cnt < 300) begin
      if (junk && cnt >= 10 && cnt < 15) begin
        wen = 2'b11; din = 16'($urandom_range(0, 65535)); start = 1'b1; ren = 1'b1;
      end else begin
        wen = 2'b00; start = 1'b0; ren = 1'b0;
      end
      step();
      cnt++;
    end
    wen = 2'b00; start = 1'b0; ren = 1'b0;
    chk("latency", 64'(cnt), 64'(NN*N + 1));
    chk("busy_in_done", 64'(busy), 64'd1);
    chk("a_full_cleared", 64'(a_full), 64'd0);
    chk("b_full_cleared", 64'(b_full), 64'd0);
    model_reset();
    step();
    chk("idle_after_done_busy", 64'(busy), 64'd0);
    chk("idle_after_done_done", 64'(done), 64'd0);
  endtask

  initial begin
    int seen;
    RST = 1'b1; wen = 2'b00; din = '0; start = 1'b0; ren = 1'b0;
    for (int n = 0; n < NN; n++) begin ma[n] = 0; mb[n] = 0; mc[n] = '0; end
    @(negedge CLK);
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_a_full", 64'(a_full), 64'd0);
    chk("rst_b_full", 64'(b_full), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    RST = 1'b0;
    step();

    // identity * (1..16)
    for (int n = 0; n < NN; n++) write_ab(2'b10, (n % (N+1) == 0) ? 16'd1 : 16'd0);
    for (int n = 0; n < NN; n++) write_ab(2'b01, 16'(n + 1));
    run_compute(1'b0, 1'b0);
    for (int n = 0; n < NN; n++) chk("identity_model", 64'(mc[n]), 64'(n + 1));
    read_c(NN);

    // most negative operands, shared din writes both matrices
    for (int n = 0; n < NN; n++) write_ab(2'b11, 16'h8000);
    run_compute(1'b0, 1'b0);
    chk("neg_model", 64'(mc[5]), 64'h1_0000_0000);
    read_c(NN);

    // 20 writes into A: wrap overwrites entries 0..3; also read old C in start cycle
    for (int n = 0; n < 20; n++) write_ab(2'b10, 16'(100 + n));
    chk("a_wrap_a0", 64'(ma[0]), 64'd116);
    for (int n = 0; n < NN; n++) write_ab(2'b01, 16'($urandom_range(0, 65535)));
    run_compute(1'b1, 1'b0);
    read_c(NN);

    // wen/start/ren while busy have no effect
    load_random();
    run_compute(1'b0, 1'b1);
    read_c(NN);

    // reset mid-compute
    load_random();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    model_reset();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_a_full", 64'(a_full), 64'd0);
    chk("abort_state", 64'(state_dbg), 64'd0);
    chk("abort_dout", 64'(dout), 64'd0);
    seen = 0;
    for (int n = 0; n < 80; n++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    chk("no_done_after_abort", 64'(seen), 64'd0);

    load_random();
    run_compute(1'b0, 1'b0);
    read_c(NN + 1);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/macc_engine.md
MACC_ENGINE -- requirements
Module: macc_engine

Interface
REQ-001 SHALL have parameter DW, default 16, meaning signed element width of A and B.
REQ-002 SHALL have parameter N, default 4, meaning square matrix dimension; legal values 2..16.
REQ-003 SHALL have derived localparam CW = 2*DW + clog2(N), the signed width of C elements.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-006 SHALL have port wen, input, 2: bit 1 writes A, bit 0 writes B.
REQ-007 SHALL have port din, input, DW, write data shared by A and B.
REQ-008 SHALL have port start, input, 1, single-cycle compute request.
REQ-009 SHALL have port busy, output, 1, high while computing.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at compute completion.
REQ-011 SHALL have port ren, input, 1, read request for the next C element.
REQ-012 SHALL have port dout, output, CW, C element data.
REQ-013 SHALL have port dout_valid, output, 1, high the cycle dout holds requested data.
REQ-014 SHALL have ports a_full and b_full, outputs, 1 each: all N*N elements of that matrix written since the last reset or compute.

Function
REQ-015 SHALL store A, B, C as N*N-entry row-major memories with internal address counters; no external address.
REQ-016 SHALL, when wen[1] is high and busy is low, write din to A[a_ptr] and increment a_ptr, wrapping N*N-1 -> 0; B likewise with wen[0]; both bits high writes both.
REQ-017 SHALL set a_full on the write at a_ptr = N*N-1 and keep it set; wrapped writes overwrite from entry 0.
REQ-018 SHALL ignore wen while busy (no write, no pointer change).
REQ-019 SHALL use FSM states IDLE, COMP, DONE.
REQ-020 SHALL go IDLE -> COMP on start with busy low, regardless of a_full/b_full; clear i, j, k to 0.
REQ-021 SHALL, each COMP cycle, compute acc_next = (k==0 ? 0 : acc) + A[i*N+k]*B[k*N+j], signed, full precision to CW bits, no saturation.
REQ-022 SHALL write acc_next to C[i*N+j] when k = N-1; k wraps to 0 and j increments; j wraps and i increments.
REQ-023 SHALL go COMP -> DONE after the cycle with i = j = k = N-1; DONE -> IDLE next cycle unconditionally.
REQ-024 SHALL assert busy in COMP and DONE only; done exactly in DONE; compute latency start-to-done = N^3 + 1 cycles.
REQ-025 SHALL, on entering DONE, clear a_ptr, b_ptr, a_full, b_full and reset the C read pointer to 0.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL, when ren is high and busy low, present C[c_ptr] on dout with dout_valid high the next cycle, then increment c_ptr, wrapping N*N-1 -> 0.
REQ-028 SHALL ignore ren while busy; dout_valid low and dout holds its last value otherwise.
REQ-029 SHALL treat start and ren in the same IDLE cycle as: read completes normally (dout_valid next cycle), compute starts.

Reset
REQ-030 SHALL, while RST high, force IDLE, busy=0, done=0, dout_valid=0, dout=0, a_full=b_full=0, all pointers and i/j/k/acc to 0.
REQ-031 SHALL abort an in-progress compute on RST with no done pulse; C memory contents need not be cleared.
REQ-032 SHALL give RST priority over wen, start, ren in the same cycle.

Verification
REQ-033 N=4, DW=16: A = identity, B = 1..16 row-major, start -> done exactly 65 cycles later; 16 reads return 1..16.
REQ-034 A and B all -32768 -> every C element = 4*2^30 = 0x1_0000_0000 (CW=34, positive), no overflow.
REQ-035 Write 20 elements to A -> a_full set at 16th write; A[0..3] hold writes 17..20.
REQ-036 wen and start asserted during busy -> memories, pointers and done timing unchanged.
REQ-037 RST asserted at compute cycle 30 -> busy low next cycle, no done, a_full=0; new load+start then completes correctly.
REQ-038 17 consecutive ren after done -> dout_valid each following cycle; 17th returns C[0] (wrap).
